// File: rtl/lock_pkg.sv
// Shared types and constants for the lock datapath: keypad FSM states,
// key geometry, code width used by the code checker, and one-hot helpers.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    EMIT,
    HOLD,
    RELEASE
  } kp_state_t;

  localparam int KEY_W       = 2;
  localparam int NUM_KEYS    = 4;
  localparam int CODE_DIGITS = 4;
  localparam int CODE_W      = KEY_W * CODE_DIGITS;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
    logic [NUM_KEYS-1:0] m;
    m = v - NUM_KEYS'(1);
    return (v != '0) && ((v & m) == '0);
  endfunction

  // Index of the (single) set bit; callers guarantee v is one-hot.
  function automatic logic [KEY_W-1:0] encode_key(input logic [NUM_KEYS-1:0] v);
    logic [KEY_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) idx = KEY_W'(i);
    end
    return idx;
  endfunction

  // One-hot pattern for a key index.
  function automatic logic [NUM_KEYS-1:0] decode_key(input logic [KEY_W-1:0] idx);
    return NUM_KEYS'(1) << idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with a configurable reset value, used to bring the
// asynchronous keypad pins into the clk domain.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_encoder.sv
// Keypad front end: synchronizes and debounces four active-low buttons and
// turns each stable single-key press into one input_value strobe with the
// key index on bits. Chords and bounce are rejected.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (repeat strobes while a key
// stays held; when undefined, exactly one strobe per press).
module keypad_encoder
  import lock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic                input_value,
  output logic [KEY_W-1:0]    bits,
  output logic                key_held
);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
`else
  localparam int CNT_MAX = DEBOUNCE_CYCLES;
`endif
  localparam int CNT_W = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic [NUM_KEYS-1:0] sync_q;
  logic [NUM_KEYS-1:0] pressed;
  kp_state_t           state;
  logic [CNT_W-1:0]    cnt;
  logic [KEY_W-1:0]    code;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_sync
    sync_2ff #(
      .WIDTH   (1),
      .RST_VAL (1'b1)
    ) u_sync (
      .clk    (clk),
      .resetn (resetn),
      .d      (key_n[i]),
      .q      (sync_q[i])
    );
  end

  assign pressed = ~sync_q;

  // Press/release FSM with shared saturating timer; outputs are registered
  // on the transition so they line up with the state they belong to.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      code        <= '0;
      input_value <= 1'b0;
      bits        <= '0;
      key_held    <= 1'b0;
    end else begin
      input_value <= 1'b0;
      case (state)
        IDLE: begin
          if (is_onehot(pressed)) begin
            code  <= encode_key(pressed);
            cnt   <= '0;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (pressed != decode_key(code)) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == DB_LAST) begin
            cnt         <= '0;
            state       <= EMIT;
            input_value <= 1'b1;
            bits        <= code;
            key_held    <= 1'b1;
          end else begin
            cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
          end
        end
        EMIT: begin
          cnt   <= '0;
          state <= HOLD;
        end
        HOLD: begin
          if (pressed == '0) begin
            cnt   <= '0;
            state <= RELEASE;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (pressed == decode_key(code)) begin
            if (cnt == RPT_LAST) begin
              cnt         <= '0;
              state       <= EMIT;
              input_value <= 1'b1;
              bits        <= code;
            end else begin
              cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
            end
          end else begin
            // Extra keys restart the repeat interval instead of strobing.
            cnt <= '0;
          end
`endif
        end
        RELEASE: begin
          if (pressed != '0) begin
            cnt   <= '0;
            state <= HOLD;
          end else if (cnt == DB_LAST) begin
            cnt      <= '0;
            state    <= IDLE;
            key_held <= 1'b0;
          end else begin
            cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
          end
        end
        default: begin
          cnt      <= '0;
          state    <= IDLE;
          key_held <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10.
// Strobe expectations are derived from the pin-to-strobe latency of 6 edges.
module tb_keypad_encoder;

  logic       clk;
  logic       resetn;
  logic [3:0] key_n;
  logic       input_value;
  logic [1:0] bits;
  logic       key_held;

  int checks;
  int failures;
  int cyc;
  int scnt;
  int stimes [8];
  int k;
  int j;

  keypad_encoder #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_CYCLES   (10)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .key_n       (key_n),
    .input_value (input_value),
    .bits        (bits),
    .key_held    (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every cycle in which the strobe is high, 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (input_value === 1'b1) begin
      if (scnt < 8) stimes[scnt] = cyc;
      scnt++;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic nedge(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    scnt     = 0;
    resetn   = 1'b0;
    key_n    = 4'hF;

    // Reset state
    nedge(3);
    check("reset_input_value", int'(input_value), 0);
    check("reset_bits", int'(bits), 0);
    check("reset_key_held", int'(key_held), 0);
    resetn = 1'b1;
    nedge(3);

    // Clean press of key 2, then release
    scnt = 0;
    key_n = 4'b1011;
    k = cyc + 1;
    nedge(20);
    check("clean_count", scnt, 1);
    check("clean_time", stimes[0], k + 6);
    check("clean_bits", int'(bits), 2);
    check("clean_held", int'(key_held), 1);
    key_n = 4'hF;
    j = cyc + 1;
    nedge(6);
    check("release_held_before", int'(key_held), 1);
    check("release_held_cyc", cyc, j + 5);
    nedge(1);
    check("release_held_after", int'(key_held), 0);
    nedge(4);

    // Bounce on key 1, then hold low
    scnt = 0;
    for (int s = 0; s < 6; s++) begin
      key_n = (s % 2 == 0) ? 4'b1101 : 4'b1111;
      nedge(2);
    end
    check("bounce_none", scnt, 0);
    key_n = 4'b1101;
    k = cyc + 1;
    nedge(20);
    check("bounce_count", scnt, 1);
    check("bounce_time", stimes[0], k + 6);
    check("bounce_bits", int'(bits), 1);

    // Extra key 2 while key 1 is held
    key_n = 4'b1001;
    nedge(20);
    check("extra_count", scnt, 1);
    check("extra_bits", int'(bits), 1);
    check("extra_held", int'(key_held), 1);
    key_n = 4'hF;
    nedge(12);
    check("extra_release_held", int'(key_held), 0);

    // Reset in the middle of debouncing key 3
    scnt = 0;
    key_n = 4'b0111;
    k = cyc + 1;
    nedge(5);
    resetn = 1'b0;
    #1;
    check("midrst_bits", int'(bits), 0);
    check("midrst_held", int'(key_held), 0);
    check("midrst_iv", int'(input_value), 0);
    nedge(3);
    resetn = 1'b1;
    k = cyc + 1;
    nedge(20);
    check("midrst_count", scnt, 1);
    check("midrst_time", stimes[0], k + 6);
    check("midrst_bits_after", int'(bits), 3);
    key_n = 4'hF;
    nedge(12);

    // Chord of keys 0 and 3, then release key 3 only
    scnt = 0;
    key_n = 4'b0110;
    nedge(30);
    check("chord_none", scnt, 0);
    check("chord_held", int'(key_held), 0);
    key_n = 4'b1110;
    k = cyc + 1;
    nedge(20);
    check("chord_count", scnt, 1);
    check("chord_time", stimes[0], k + 6);
    check("chord_bits", int'(bits), 0);
    key_n = 4'hF;
    nedge(12);

    // Long hold of key 0
    scnt = 0;
    key_n = 4'b1110;
    k = cyc + 1;
    nedge(46);
    key_n = 4'hF;
    nedge(20);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("repeat_count", scnt, 4);
    check("repeat_t0", stimes[0], k + 6);
    check("repeat_t1", stimes[1], k + 17);
    check("repeat_t3", stimes[3], k + 39);
`else
    check("hold_count", scnt, 1);
    check("hold_time", stimes[0], k + 6);
`endif
    check("hold_bits", int'(bits), 0);
    check("hold_released", int'(key_held), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
